// File: rtl/hit_cb_ctrl_if.sv
// Output stream bundle for the hit circular-buffer controller.
// Ports: dout (word), doutValid (valid), doutReady (ready); master drives word/valid.
interface hit_cb_ctrl_if #(
    parameter int DW = 8
);
    logic [DW-1:0] dout;
    logic          doutValid;
    logic          doutReady;

    modport master (
        output dout,
        output doutValid,
        input  doutReady
    );

    modport slave (
        input  dout,
        input  doutValid,
        output doutReady
    );
endinterface

// File: rtl/hit_cb_ctrl.sv
// Hit circular-buffer controller: writes one hit per clock, queues L1A read
// addresses, reads triggered words back and streams them out.
// Ports: clk/reset, enable/hitIn (write side), latency/L1A (trigger),
// CENB/AB/DB (memory write port), CENA/AA/QA (memory read port), RET1N,
// stream (dout/doutValid/doutReady), l1aDropCnt (saturating drop count).
module hit_cb_ctrl #(
    parameter int AW = 7,
    parameter int DW = 8,
    parameter int QD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [DW-1:0] hitIn,
    input  logic [AW-1:0] latency,
    input  logic          L1A,
    output logic          CENB,
    output logic [AW-1:0] AB,
    output logic [DW-1:0] DB,
    output logic          CENA,
    output logic [AW-1:0] AA,
    input  logic [DW-1:0] QA,
    output logic          RET1N,
    output logic [7:0]    l1aDropCnt,
    hit_cb_ctrl_if.master stream
);
    localparam int PW = $clog2(QD);

    typedef enum logic [1:0] {
        IDLE,
        LAT,
        OUT
    } state_t;

    state_t        state;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] aa_hold;
    logic [AW-1:0] fifo_mem [QD];
    logic [PW:0]   fifo_wr;
    logic [PW:0]   fifo_rd;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [AW-1:0] target;
    logic [AW-1:0] head;

    assign AB    = wr_addr;
    assign DB    = hitIn;
    assign CENB  = ~enable;
    assign RET1N = 1'b1;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign fifo_empty = (fifo_wr == fifo_rd);
    assign fifo_full  = (fifo_wr[PW] != fifo_rd[PW]) &&
                        (fifo_wr[PW-1:0] == fifo_rd[PW-1:0]);
    assign head       = fifo_mem[fifo_rd[PW-1:0]];

    // The read is issued in the same cycle the head is popped, so a trigger
    // reaches the memory one cycle after it is captured.
    assign pop  = (state == IDLE) && !fifo_empty;
    assign push = L1A && (!fifo_full || pop);
    assign drop = L1A && fifo_full && !pop;

    // Modulo-2^AW wrap subtraction.
    assign target = wr_addr - latency;

    assign CENA = ~pop;
    assign AA   = pop ? head : aa_hold;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wr[PW-1:0]] <= target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr          <= '0;
            aa_hold          <= '0;
            fifo_wr          <= '0;
            fifo_rd          <= '0;
            l1aDropCnt       <= '0;
            state            <= IDLE;
            stream.dout      <= '0;
            stream.doutValid <= 1'b0;
        end else begin
            if (enable) begin
                wr_addr <= wr_addr + AW'(1);
            end
            if (push) begin
                fifo_wr <= fifo_wr + (PW + 1)'(1);
            end
            if (pop) begin
                fifo_rd <= fifo_rd + (PW + 1)'(1);
                aa_hold <= head;
            end
            if (drop && (l1aDropCnt != 8'hFF)) begin
                l1aDropCnt <= l1aDropCnt + 8'd1;
            end
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state <= LAT;
                    end
                end
                LAT: begin
                    stream.dout      <= QA;
                    stream.doutValid <= 1'b1;
                    state            <= OUT;
                end
                OUT: begin
                    if (stream.doutReady) begin
                        stream.doutValid <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hit_cb_ctrl.sv
// Self-checking bench for hit_cb_ctrl with an attached 128x8 memory model.
// Expected words are queued when triggers are driven and compared on output.
module tb_hit_cb_ctrl;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] hitIn;
    logic [AW-1:0] latency;
    logic          L1A;
    logic          CENB;
    logic [AW-1:0] AB;
    logic [DW-1:0] DB;
    logic          CENA;
    logic [AW-1:0] AA;
    logic [DW-1:0] QA;
    logic          RET1N;
    logic [7:0]    l1aDropCnt;

    hit_cb_ctrl_if #(.DW(DW)) stream ();

    hit_cb_ctrl #(.AW(AW), .DW(DW), .QD(QD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .hitIn      (hitIn),
        .latency    (latency),
        .L1A        (L1A),
        .CENB       (CENB),
        .AB         (AB),
        .DB         (DB),
        .CENA       (CENA),
        .AA         (AA),
        .QA         (QA),
        .RET1N      (RET1N),
        .l1aDropCnt (l1aDropCnt),
        .stream     (stream)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [128];

    always @(posedge clk) begin
        if (!CENB) ram[AB] <= DB;
        if (!CENA) QA <= ram[AA];
    end

    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] tb_wr;
    logic [DW-1:0] hist [128];
    logic [DW-1:0] sbq [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic          last_stall = 1'b0;
    logic [DW-1:0] last_dout;

    always @(negedge clk) begin
        if (reset) begin
            last_stall = 1'b0;
        end else begin
            if (stream.doutValid && last_stall)
                chk("dout_stable", 32'(stream.dout), 32'(last_dout));
            if (stream.doutValid && stream.doutReady) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_out: got %0h expected none",
                           stream.dout);
                end else begin
                    chk("dout", 32'(stream.dout), 32'(sbq.pop_front()));
                end
            end
            last_stall = stream.doutValid && !stream.doutReady;
            last_dout  = stream.dout;
        end
    end

    task automatic step(input logic en, input logic [DW-1:0] h,
                        input logic l1a, input logic exp_push);
        logic [AW-1:0] tgt;
        enable = en;
        hitIn  = h;
        L1A    = l1a;
        #1;
        chk("AB", 32'(AB), 32'(tb_wr));
        chk("CENB", 32'(CENB), 32'(!en));
        if (en) hist[tb_wr] = h;
        tgt = tb_wr - latency;
        if (l1a && exp_push) sbq.push_back(hist[tgt]);
        @(posedge clk);
        #1;
        if (reset) tb_wr = '0;
        else if (en) tb_wr = tb_wr + AW'(1);
    endtask

    task automatic drain(input int bound, input logic en);
        int n = 0;
        while (sbq.size() != 0 && n < bound) begin
            step(en, 8'($urandom), 1'b0, 1'b0);
            n++;
        end
        chk("drain_left", 32'(sbq.size()), 32'd0);
        step(en, 8'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        enable           = 1'b0;
        hitIn            = '0;
        latency          = '0;
        L1A              = 1'b0;
        stream.doutReady = 1'b0;
        tb_wr            = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(stream.doutValid), 32'd0);
        chk("rst_dout", 32'(stream.dout), 32'd0);
        chk("rst_cena", 32'(CENA), 32'd1);
        chk("rst_aa", 32'(AA), 32'd0);
        chk("rst_ab", 32'(AB), 32'd0);
        chk("rst_drop", 32'(l1aDropCnt), 32'd0);
        chk("ret1n", 32'(RET1N), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 127) chk("ab_wrap", 32'(AB), 32'd0);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 8'($urandom), 1'b0, 1'b0);
        chk("ab_frozen", 32'(AB), 32'd44);

        stream.doutReady = 1'b1;
        latency = 7'd10;
        while (tb_wr != 7'd50) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'($urandom), 1'b1, 1'b1);
        chk("aa_basic", 32'(AA), 32'd40);
        chk("cena_basic", 32'(CENA), 32'd0);
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("valid_t2", 32'(stream.doutValid), 32'd0);
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("valid_t3", 32'(stream.doutValid), 32'd1);
        chk("dout_basic", 32'(stream.dout), 32'(hist[40]));
        drain(10, 1'b1);

        latency = 7'd20;
        while (tb_wr != 7'd5) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'($urandom), 1'b1, 1'b1);
        chk("aa_wrap", 32'(AA), 32'd113);
        drain(10, 1'b1);

        latency = 7'd0;
        step(1'b1, 8'hA5, 1'b1, 1'b1);
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("dout_lat0", 32'(stream.dout), 32'hA5);
        drain(10, 1'b1);

        latency = 7'd10;
        stream.doutReady = 1'b0;
        for (int k = 0; k < 6; k++)
            step(1'b1, 8'($urandom), 1'b1, 1'(k < 5));
        chk("drop_one", 32'(l1aDropCnt), 32'd1);
        chk("valid_stall", 32'(stream.doutValid), 32'd1);
        for (int k = 0; k < 3; k++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        stream.doutReady = 1'b1;
        drain(40, 1'b1);
        chk("drop_kept", 32'(l1aDropCnt), 32'd1);

        stream.doutReady = 1'b0;
        for (int k = 0; k < 300; k++)
            step(1'b0, 8'($urandom), 1'b1, 1'(k < 5));
        chk("drop_sat", 32'(l1aDropCnt), 32'd255);
        for (int k = 0; k < 3; k++) step(1'b0, 8'($urandom), 1'b1, 1'b0);
        chk("drop_hold", 32'(l1aDropCnt), 32'd255);
        stream.doutReady = 1'b1;
        drain(40, 1'b0);

        stream.doutReady = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b1, 8'($urandom), 1'b1, 1'b1);
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(stream.doutValid), 32'd1);
        reset = 1'b1;
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("mid_rst_valid", 32'(stream.doutValid), 32'd0);
        chk("mid_rst_cena", 32'(CENA), 32'd1);
        chk("mid_rst_ab", 32'(AB), 32'd0);
        chk("mid_rst_drop", 32'(l1aDropCnt), 32'd0);
        sbq.delete();
        reset = 1'b0;
        stream.doutReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
            chk("post_rst_quiet", 32'(stream.doutValid), 32'd0);
        end
        latency = 7'd3;
        step(1'b1, 8'($urandom), 1'b1, 1'b1);
        chk("aa_post_rst", 32'(AA), 32'(7'd7));
        drain(10, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hit_cb_ctrl.md
Name: hit_cb_ctrl

Overview:
Controller for the 128x8 hit circular buffer register file. It writes one hit word per clock through the buffer's write port, and queues L1A triggers as read addresses. It reads the triggered words back through the registered read port and presents them on a valid/ready output. Sits between the pixel hit-formatting stage and the readout serialiser. Both memory ports are clocked from the block's single clock.

Parameters:
AW, 7, buffer address width (depth = 2^AW = 128)
DW, 8, hit word width
QD, 4, L1A pending-address FIFO depth (power of 2)

Ports:
clk  in  1  system clock, also drives memory CLKA/CLKB
reset  in  1  synchronous, active-high reset
enable  in  1  write-side enable; freezes write pointer when low
hitIn  in  DW  hit word for current cycle
latency  in  AW  L1A latency in clock cycles, static during run
L1A  in  1  trigger pulse, one cycle per trigger
CENB  out  1  memory write enable, active low
AB  out  AW  memory write address
DB  out  DW  memory write data
CENA  out  1  memory read enable, active low
AA  out  AW  memory read address
QA  in  DW  memory read data, valid the cycle after CENA low
RET1N  out  1  memory retention control, constant 1
dout  out  DW  triggered hit word
doutValid  out  1  dout valid
doutReady  in  1  downstream accepts dout
l1aDropCnt  out  8  saturating count of L1As dropped on full FIFO

Behaviour:
- Reset values: wrAddr=0, FIFO empty, FSM=IDLE, dout=0, doutValid=0, CENA=1, AA=0, l1aDropCnt=0.
- Write side:
  - AB=wrAddr, DB=hitIn, CENB=~enable (combinational).
  - Each cycle with enable=1, wrAddr increments mod 128 (127->0).
  - With enable=0, wrAddr holds and no write occurs.
- L1A capture:
  - On a cycle with L1A=1 and wrAddr=W, target=(W-latency) mod 2^AW (AW-bit wrap subtraction).
  - The target is pushed into the QD-deep FIFO.
  - If the FIFO is full and no pop occurs that cycle, the L1A is dropped and l1aDropCnt increments, saturating at 255.
  - A simultaneous push and pop on a full FIFO is accepted.
  - L1A is accepted regardless of enable.
- Read FSM:
  - IDLE: if FIFO non-empty, drive CENA=0 and AA=FIFO head, pop; next state LAT. Otherwise CENA=1 and AA holds.
  - LAT: CENA=1; register dout<=QA and doutValid<=1; next state OUT.
  - OUT: hold dout/doutValid stable until doutReady=1. On the acceptance cycle, doutValid<=0 and next state is IDLE.
- Latency: an L1A in cycle T with an empty FIFO and idle FSM gives a read issue in T+1 and doutValid=1 from T+3. Throughput is at most one word per 3 cycles with doutReady tied high.
- Data freshness:
  - latency=0 returns the word written in the L1A cycle.
  - A word is overwritten once the write pointer laps it. Stale data is not detected or flagged, and system setup must keep queueing delay below 128-latency cycles.
- doutReady while doutValid=0 is ignored.
- Reset mid-operation: pending FIFO entries and any in-flight read are discarded. doutValid=0 and CENA=1 in the cycle after reset asserts.

Test Plan:
- Write/wrap: reset, enable=1, hitIn=cycle index mod 256 for 300 cycles -> AB counts 0..127 then wraps to 0; CENB=0 throughout; enable=0 for 5 cycles -> AB frozen, CENB=1.
- Basic trigger: latency=10, memory model attached, L1A when wrAddr=50 -> AA=40 with CENA=0 one cycle later; doutValid=1 three cycles after L1A; dout = word written at address 40.
- Wrap subtraction: latency=20, L1A at wrAddr=5 -> AA=113; latency=0 -> dout equals the hitIn of the L1A cycle.
- Backpressure/overflow: doutReady=0, 6 back-to-back L1As -> first read into OUT, 4 queued, 1 dropped, l1aDropCnt=1; raise doutReady -> remaining 4 words emerge in order, dout stable while stalled.
- Drop saturation: doutReady=0, 300 L1As -> l1aDropCnt=255 and holds.
- Reset mid-op: assert reset with 3 pending and doutValid=1 -> next cycle doutValid=0, CENA=1, AB=0. No further output after release until a new L1A arrives.
